// File: rtl/rfs_bt_uart_rx.sv
// rfs_bt_uart_rx: 16x-oversampled UART receiver with a byte FIFO behind an Avalon-MM slave and a level irq.
// Optional feature macro: RFS_BT_UART_PARITY_EN adds an even-parity bit after the 8 data bits.
module rfs_bt_uart_rx #(
    parameter int DIV_DEFAULT = 27,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      DIV_RESET = 16'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAITHI = 3'd5;
`ifdef RFS_BT_UART_PARITY_EN
    localparam logic [2:0] S_PAR        = 3'd3;
    localparam logic [2:0] S_AFTER_DATA = S_PAR;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic                 r_rxd_meta;
    logic                 r_rxd_sync;
    logic [15:0]          r_div;
    logic                 r_irq_en;
    logic [15:0]          r_tick_cnt;
    logic [2:0]           r_state;
    logic [3:0]           r_samp_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_oe;
    logic                 r_fe;
    logic                 r_irq;
    logic [31:0]          r_readdata;

    logic                 w_rd_data;
    logic                 w_wr_status;
    logic                 w_wr_baud;
    logic                 w_wr_ctrl;
    logic [15:0]          w_div_eff;
    logic [15:0]          w_new_div_eff;
    logic                 w_tick;
    logic                 w_stop_sample;
    logic                 w_push;
    logic                 w_fe_set;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_push_ok;
    logic                 w_oe_set;
    logic                 w_pe;
    logic [31:0]          w_status;
    logic                 w_unused;

    assign w_unused = ^avs_writedata[31:16];

    assign w_rd_data   = avs_read  && (avs_address == 2'd0);
    assign w_wr_status = avs_write && (avs_address == 2'd1);
    assign w_wr_baud   = avs_write && (avs_address == 2'd2);
    assign w_wr_ctrl   = avs_write && (avs_address == 2'd3);

    // The pin is asynchronous; nothing downstream may look at rxd before these two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= DIV_RESET;
            r_irq_en <= 1'b0;
        end else begin
            if (w_wr_baud) begin
                r_div <= avs_writedata[15:0];
            end
            if (w_wr_ctrl) begin
                r_irq_en <= avs_writedata[0];
            end
        end
    end

    // A divisor of 0 would tick every cycle with no reload gap, so it is treated as 1.
    assign w_div_eff     = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_new_div_eff = (avs_writedata[15:0] == 16'd0) ? 16'd1 : avs_writedata[15:0];
    assign w_tick        = (r_tick_cnt == 16'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= (DIV_RESET == 16'd0) ? 16'd1 : DIV_RESET;
        end else if (w_wr_baud) begin
            r_tick_cnt <= w_new_div_eff;
        end else if (w_tick) begin
            r_tick_cnt <= w_div_eff;
        end else begin
            r_tick_cnt <= r_tick_cnt - 16'd1;
        end
    end

`ifdef RFS_BT_UART_PARITY_EN
    logic r_par_bit;
`endif

    // Start is confirmed at mid-bit (tick 7); every later bit is sampled 16 ticks after the previous one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_samp_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
`ifdef RFS_BT_UART_PARITY_EN
            r_par_bit  <= 1'b0;
`endif
        end else if (w_wr_baud) begin
            r_state    <= S_IDLE;
            r_samp_cnt <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxd_sync) begin
                        r_state    <= S_START;
                        r_samp_cnt <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_samp_cnt == 4'd7) begin
                            r_samp_cnt <= 4'd0;
                            r_bit_cnt  <= 3'd0;
                            r_state    <= r_rxd_sync ? S_IDLE : S_DATA;
                        end else begin
                            r_samp_cnt <= r_samp_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + 4'd1;
                        if (r_samp_cnt == 4'd15) begin
                            r_shift   <= {r_rxd_sync, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= S_AFTER_DATA;
                            end
                        end
                    end
                end
`ifdef RFS_BT_UART_PARITY_EN
                S_PAR: begin
                    if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + 4'd1;
                        if (r_samp_cnt == 4'd15) begin
                            r_par_bit <= r_rxd_sync;
                            r_state   <= S_STOP;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + 4'd1;
                        if (r_samp_cnt == 4'd15) begin
                            r_state <= r_rxd_sync ? S_IDLE : S_WAITHI;
                        end
                    end
                end
                S_WAITHI: begin
                    if (r_rxd_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_stop_sample = (r_state == S_STOP) && w_tick && (r_samp_cnt == 4'd15) && !w_wr_baud;
    assign w_push        = w_stop_sample && r_rxd_sync;
    assign w_fe_set      = w_stop_sample && !r_rxd_sync;

    // A pop in the same cycle frees the slot, so a push into a full FIFO only overruns without one.
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = w_rd_data && (r_count != '0);
    assign w_flush   = w_wr_ctrl && avs_writedata[1];
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_oe_set  = w_push && w_full && !w_pop && !w_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !w_flush) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_oe <= 1'b0;
            r_fe <= 1'b0;
        end else begin
            r_oe <= w_oe_set | (r_oe & ~(w_wr_status & avs_writedata[8]));
            r_fe <= w_fe_set | (r_fe & ~(w_wr_status & avs_writedata[9]));
        end
    end

`ifdef RFS_BT_UART_PARITY_EN
    logic r_pe;
    logic w_pe_set;

    assign w_pe_set = w_push && ((^r_shift) ^ r_par_bit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pe <= 1'b0;
        end else begin
            r_pe <= w_pe_set | (r_pe & ~(w_wr_status & avs_writedata[10]));
        end
    end

    assign w_pe = r_pe;
`else
    assign w_pe = 1'b0;
`endif

    always_comb begin
        w_status     = 32'(r_count);
        w_status[8]  = r_oe;
        w_status[9]  = r_fe;
        w_status[10] = w_pe;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else if (avs_read) begin
            case (avs_address)
                2'd0:    r_readdata <= (r_count != '0) ? {23'd0, 1'b1, r_mem[r_rd_ptr]} : 32'd0;
                2'd1:    r_readdata <= w_status;
                2'd2:    r_readdata <= {16'd0, r_div};
                default: r_readdata <= {31'd0, r_irq_en};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & ((r_count != '0) | r_oe | r_fe | w_pe);
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_rfs_bt_uart_rx.sv
// Self-checking bench for rfs_bt_uart_rx: randomized frames checked against a queue-based receiver model.
// Build with RFS_BT_UART_PARITY_EN defined to also exercise the parity path.
module tb_rfs_bt_uart_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rxd = 1'b1;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [7:0] modelQ[$];
    logic       modelOe = 1'b0;
    logic       modelFe = 1'b0;
    logic       modelPe = 1'b0;

`ifdef RFS_BT_UART_PARITY_EN
    localparam int FRAME_TICKS = 168;
`else
    localparam int FRAME_TICKS = 152;
`endif
    // Divisor 12 gives a tick every 13 clocks; the stop bit is judged on the last tick of the frame.
    localparam int ALIGN_DIV   = 12;
    localparam int ALIGN_EDGE  = (ALIGN_DIV + 1) * FRAME_TICKS;

    rfs_bt_uart_rx dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rxd           (rxd),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .irq           (irq)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        waitClocks(1);
        avs_write     = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        waitClocks(1);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    // Drives one full frame on rxd; the line is left idle-high afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parBit, input int bitClk);
        rxd = 1'b0;
        waitClocks(bitClk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            waitClocks(bitClk);
        end
`ifdef RFS_BT_UART_PARITY_EN
        rxd = parBit;
        waitClocks(bitClk);
`endif
        rxd = stopBit;
        waitClocks(bitClk);
        rxd = 1'b1;
    endtask

    function automatic void modelPush(input logic [7:0] b);
        if (modelQ.size() >= 16) modelOe = 1'b1;
        else modelQ.push_back(b);
    endfunction

    function automatic logic [31:0] expStatus();
        return (32'(modelPe) << 10) | (32'(modelFe) << 9) | (32'(modelOe) << 8) | 32'(modelQ.size());
    endfunction

    function automatic logic [31:0] expPop();
        logic [7:0] b;
        b = modelQ.pop_front();
        return 32'h100 | 32'(b);
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;

        waitClocks(3);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);
        checkOutput("reset readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        waitClocks(2);
        busRead(2'd1, rd); checkOutput("reset STATUS", rd, 32'd0);
        busRead(2'd2, rd); checkOutput("reset BAUD", rd, 32'd27);
        busRead(2'd3, rd); checkOutput("reset CTRL", rd, 32'd0);
        busRead(2'd0, rd); checkOutput("reset DATA empty", rd, 32'd0);

        $display("[TB] single byte at default divisor");
        applyStimulus(8'h55, 1'b1, 1'b0, 28 * 16);
        modelPush(8'h55);
        busRead(2'd1, rd); checkOutput("0x55 STATUS", rd, expStatus());
        checkOutput("irq disabled", {31'd0, irq}, 32'd0);
        busRead(2'd0, rd); checkOutput("0x55 DATA", rd, expPop());
        busRead(2'd0, rd); checkOutput("DATA after drain", rd, 32'd0);

        $display("[TB] overrun with divisor 0");
        busWrite(2'd2, 32'd0);
        busRead(2'd2, rd); checkOutput("BAUD=0 readback", rd, 32'd0);
        busWrite(2'd3, 32'd1);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, ^b, 32);
            modelPush(b);
        end
        busRead(2'd1, rd); checkOutput("overrun STATUS", rd, expStatus());
        checkOutput("overrun irq", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            busRead(2'd0, rd); checkOutput("overrun DATA", rd, expPop());
        end
        busRead(2'd1, rd); checkOutput("drained STATUS", rd, expStatus());
        busWrite(2'd1, 32'h100);
        modelOe = 1'b0;
        waitClocks(2);
        busRead(2'd1, rd); checkOutput("OE cleared", rd, expStatus());
        checkOutput("irq after clear", {31'd0, irq}, 32'd0);

        $display("[TB] glitch and framing error");
        rxd = 1'b0;
        waitClocks(10);
        rxd = 1'b1;
        waitClocks(64);
        busRead(2'd1, rd); checkOutput("glitch STATUS", rd, expStatus());
        applyStimulus(8'hA3, 1'b0, ^8'hA3, 32);
        rxd = 1'b0;
        waitClocks(96);
        rxd = 1'b1;
        waitClocks(32);
        modelFe = 1'b1;
        busRead(2'd1, rd); checkOutput("FE STATUS", rd, expStatus());
        checkOutput("FE irq", {31'd0, irq}, 32'd1);
        applyStimulus(8'h3C, 1'b1, ^8'h3C, 32);
        modelPush(8'h3C);
        busRead(2'd0, rd); checkOutput("after break DATA", rd, expPop());
        busWrite(2'd1, 32'h200);
        modelFe = 1'b0;
        busRead(2'd1, rd); checkOutput("FE cleared", rd, expStatus());

        $display("[TB] divisor 12");
        busWrite(2'd2, 32'd12);
        busRead(2'd2, rd); checkOutput("BAUD=12 readback", rd, 32'd12);
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hC3 : 8'($urandom);
            applyStimulus(b, 1'b1, ^b, 13 * 16);
            modelPush(b);
            busRead(2'd0, rd); checkOutput("DIV12 DATA", rd, expPop());
        end

        fork
            applyStimulus(8'hFF, 1'b1, 1'b0, 13 * 16);
            begin
                waitClocks(4 * 13 * 16 + 50);
                busWrite(2'd2, 32'd12);
            end
        join
        waitClocks(2 * 13 * 16);
        busRead(2'd1, rd); checkOutput("BAUD mid-frame STATUS", rd, expStatus());

        $display("[TB] pop and push on a full FIFO in the same cycle");
        busWrite(2'd2, 32'd0);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, ^b, 32);
            modelPush(b);
        end
        busRead(2'd1, rd); checkOutput("full STATUS", rd, expStatus());
        b = 8'($urandom);
        busWrite(2'd2, ALIGN_DIV);
        fork
            applyStimulus(b, 1'b1, ^b, (ALIGN_DIV + 1) * 16);
            begin
                waitClocks(ALIGN_EDGE - 1);
                busRead(2'd0, rd);
            end
        join
        checkOutput("same-cycle pop DATA", rd, expPop());
        modelPush(b);
        busRead(2'd1, rd); checkOutput("same-cycle pop STATUS", rd, expStatus());
        for (int i = 0; i < 16; i++) begin
            busRead(2'd0, rd); checkOutput("full drain DATA", rd, expPop());
        end

        $display("[TB] flush and push in the same cycle");
        b = 8'($urandom);
        applyStimulus(b, 1'b1, ^b, (ALIGN_DIV + 1) * 16);
        modelPush(b);
        b = 8'($urandom);
        busWrite(2'd2, ALIGN_DIV);
        fork
            applyStimulus(b, 1'b1, ^b, (ALIGN_DIV + 1) * 16);
            begin
                waitClocks(ALIGN_EDGE - 1);
                busWrite(2'd3, 32'd3);
            end
        join
        modelQ.delete();
        waitClocks(2);
        busRead(2'd1, rd); checkOutput("flush STATUS", rd, expStatus());
        busRead(2'd3, rd); checkOutput("CTRL after flush", rd, 32'd1);
        checkOutput("flush irq", {31'd0, irq}, 32'd0);

`ifdef RFS_BT_UART_PARITY_EN
        $display("[TB] parity");
        applyStimulus(8'h07, 1'b1, 1'b0, (ALIGN_DIV + 1) * 16);
        modelPush(8'h07);
        modelPe = 1'b1;
        busRead(2'd1, rd); checkOutput("PE set STATUS", rd, expStatus());
        busRead(2'd0, rd); checkOutput("PE DATA", rd, expPop());
        busWrite(2'd1, 32'h400);
        modelPe = 1'b0;
        applyStimulus(8'h07, 1'b1, 1'b1, (ALIGN_DIV + 1) * 16);
        modelPush(8'h07);
        busRead(2'd1, rd); checkOutput("good parity STATUS", rd, expStatus());
        busRead(2'd0, rd); checkOutput("good parity DATA", rd, expPop());
`endif

        $display("[TB] reset mid-frame");
        b = 8'($urandom);
        applyStimulus(b, 1'b1, ^b, (ALIGN_DIV + 1) * 16);
        rxd = 1'b0;
        waitClocks(3 * (ALIGN_DIV + 1) * 16);
        reset_n = 1'b0;
        rxd = 1'b1;
        modelQ.delete();
        waitClocks(3);
        checkOutput("mid-frame reset irq", {31'd0, irq}, 32'd0);
        checkOutput("mid-frame reset readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        waitClocks(3);
        busRead(2'd1, rd); checkOutput("post-reset STATUS", rd, expStatus());
        busRead(2'd2, rd); checkOutput("post-reset BAUD", rd, 32'd27);
        busRead(2'd3, rd); checkOutput("post-reset CTRL", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
